// File: rtl/io_port_bank.sv
// Memory-mapped input-port bank: per-channel 2-flop sync, debounce, sticky change flags, registered read port.
// Define IO_SNAPSHOT_EN to latch all channels into shadow registers on each status read.
module io_port_bank #(
    parameter int unsigned NCH        = 3,
    parameter int unsigned IN_W       = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NCH*IN_W-1:0]   in_port,
    input  logic [NCH-1:0]        sign_ext,
    input  logic                  rd_en,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  chg_irq
);

    typedef enum logic {IDLE, COUNT} deb_state_t;

    logic [IN_W-1:0] stable_q [NCH];
    logic [NCH-1:0]  chg_set;
    logic [NCH-1:0]  flag;
    logic [NCH-1:0]  flag_nx;
    logic            stat_rd;
    logic [DATA_W-1:0] rd_val;

    assign stat_rd = rd_en && (rd_sel == SEL_W'(NCH));

    function automatic logic [DATA_W-1:0] extend(input logic [IN_W-1:0] v, input logic s);
        logic [DATA_W-1:0] r;
        r = {DATA_W{s & v[IN_W-1]}};
        r[IN_W-1:0] = v;
        return r;
    endfunction

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [IN_W-1:0] sync1, sync2, stable;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                sync1 <= '0;
                sync2 <= '0;
            end else begin
                sync1 <= in_port[k*IN_W +: IN_W];
                sync2 <= sync1;
            end
        end

        if (DEB_CYCLES > 0) begin : g_deb
            localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
            deb_state_t      state, state_nx;
            logic [CNT_W-1:0] cnt, cnt_nx;
            logic [IN_W-1:0] cand, cand_nx;
            logic            reach;
            logic            ld;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    cand   <= '0;
                    stable <= '0;
                end else begin
                    state <= state_nx;
                    cnt   <= cnt_nx;
                    cand  <= cand_nx;
                    if (ld)
                        stable <= cand_nx;
                end
            end

            // Terminal count is checked on the updated counter so the load lands on the edge it reaches DEB_CYCLES.
            always_comb begin
                state_nx = state;
                cnt_nx   = cnt;
                cand_nx  = cand;
                reach    = 1'b0;
                case (state)
                    IDLE: begin
                        if (sync2 != stable) begin
                            state_nx = COUNT;
                            cand_nx  = sync2;
                            cnt_nx   = CNT_W'(1);
                        end
                    end
                    COUNT: begin
                        if (sync2 == cand) begin
                            cnt_nx = cnt + 1'b1;
                        end else if (sync2 != stable) begin
                            cand_nx = sync2;
                            cnt_nx  = CNT_W'(1);
                        end else begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
                if (state_nx == COUNT && cnt_nx == CNT_W'(DEB_CYCLES)) begin
                    reach    = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end

            always_comb begin
                ld         = reach;
                chg_set[k] = reach && (cand_nx != stable);
            end
        end else begin : g_nodeb
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn)
                    stable <= '0;
                else
                    stable <= sync2;
            end

            assign chg_set[k] = (sync2 != stable);
        end

        assign stable_q[k] = stable;
    end

`ifdef IO_SNAPSHOT_EN
    logic [IN_W-1:0] shadow [NCH];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned k = 0; k < NCH; k++)
                shadow[k] <= '0;
        end else if (stat_rd) begin
            for (int unsigned k = 0; k < NCH; k++)
                shadow[k] <= stable_q[k];
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (rd_sel == SEL_W'(k)) begin
`ifdef IO_SNAPSHOT_EN
                rd_val = extend(shadow[k], sign_ext[k]);
`else
                rd_val = extend(stable_q[k], sign_ext[k]);
`endif
            end
        end
        if (rd_sel == SEL_W'(NCH))
            rd_val = DATA_W'(flag);
    end

    // Set beats clear when a flag rises in the same cycle as a status read.
    assign flag_nx = (flag & ~{NCH{stat_rd}}) | chg_set;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flag     <= '0;
            chg_irq  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            flag     <= flag_nx;
            chg_irq  <= |flag_nx;
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_val;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank (NCH=3, IN_W=4, DATA_W=32, DEB_CYCLES=4, SEL_W=3).
// Expectations follow IO_SNAPSHOT_EN when the bench is built with it defined.
module tb_io_port_bank;

    logic        clock;
    logic        resetn;
    logic [11:0] in_port;
    logic [2:0]  sign_ext;
    logic        rd_en;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        chg_irq;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [2:0] STAT = 3'd3;

    io_port_bank #(
        .NCH(3),
        .IN_W(4),
        .DATA_W(32),
        .DEB_CYCLES(4),
        .SEL_W(3)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .in_port(in_port),
        .sign_ext(sign_ext),
        .rd_en(rd_en),
        .rd_sel(rd_sel),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .chg_irq(chg_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_read(input string tag, input logic [2:0] sel, input logic [2:0] sx,
                           input logic [31:0] exp);
        rd_en    = 1'b1;
        rd_sel   = sel;
        sign_ext = sx;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check(tag, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        in_port  = 12'h000;
        sign_ext = 3'b000;
        rd_en    = 1'b0;
        rd_sel   = 3'd0;
        tick(3);
        check("rst_data", rd_data, 32'h0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_irq", {31'd0, chg_irq}, 32'd0);
        resetn = 1'b1;
        tick(3);
        check("idle_irq", {31'd0, chg_irq}, 32'd0);
        check("idle_valid", {31'd0, rd_valid}, 32'd0);

        // first read: valid only after the edge that samples rd_en
        rd_en  = 1'b1;
        rd_sel = 3'd0;
        #1;
        check("rd0_pre_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        rd_en = 1'b0;
        check("rd0_valid", {31'd0, rd_valid}, 32'd1);
        check("rd0_data", rd_data, 32'h0);
        tick();
        check("rd0_valid_drop", {31'd0, rd_valid}, 32'd0);

        // ch1 -> A: stable (and irq) on the 6th edge
        in_port = 12'h0A0;
        tick(5);
        check("ch1_irq_early", {31'd0, chg_irq}, 32'd0);
        tick();
        check("ch1_irq_set", {31'd0, chg_irq}, 32'd1);
        do_read("stat_ch1", STAT, 3'b000, 32'h2);
        check("stat_clr_irq", {31'd0, chg_irq}, 32'd0);
        do_read("stat_empty", STAT, 3'b000, 32'h0);
        do_read("ch1_zx", 3'd1, 3'b000, 32'h0000000A);
        do_read("ch1_sx", 3'd1, 3'b010, 32'hFFFFFFFA);

        // ch0 glitch of 2 raw cycles is rejected
        in_port = 12'h0A5;
        tick(2);
        in_port = 12'h0A0;
        tick(8);
        check("glitch_irq", {31'd0, chg_irq}, 32'd0);
        do_read("glitch_stat", STAT, 3'b000, 32'h0);

        // candidate 5 -> 6 mid-count restarts the counter
        in_port = 12'h0A5;
        tick(2);
        in_port = 12'h0A6;
        tick(5);
        check("restart_irq_early", {31'd0, chg_irq}, 32'd0);
        tick();
        check("restart_irq_set", {31'd0, chg_irq}, 32'd1);
        do_read("restart_stat", STAT, 3'b000, 32'h1);
        do_read("restart_ch0", 3'd0, 3'b001, 32'h00000006);

        // ch2 -> C, extension modes and unmapped selects
        in_port = 12'hCA6;
        tick(6);
        do_read("ch2_stat", STAT, 3'b000, 32'h4);
        do_read("ch2_sx", 3'd2, 3'b100, 32'hFFFFFFFC);
        do_read("ch2_zx", 3'd2, 3'b000, 32'h0000000C);
        do_read("unmapped5", 3'd5, 3'b111, 32'h0);
        do_read("unmapped4", 3'd4, 3'b111, 32'h0);

        // back-to-back reads, then hold
        rd_en    = 1'b1;
        rd_sel   = 3'd0;
        sign_ext = 3'b000;
        tick();
        check("b2b0_valid", {31'd0, rd_valid}, 32'd1);
        check("b2b0_data", rd_data, 32'h6);
        rd_sel = 3'd1;
        tick();
        rd_en = 1'b0;
        check("b2b1_valid", {31'd0, rd_valid}, 32'd1);
        check("b2b1_data", rd_data, 32'hA);
        rd_sel = 3'd2;
        tick();
        check("hold_valid", {31'd0, rd_valid}, 32'd0);
        check("hold_data", rd_data, 32'hA);

        // flag set on the same edge as a status-read clear
        in_port = 12'hC36;
        tick(5);
        rd_en  = 1'b1;
        rd_sel = STAT;
        tick();
        rd_en = 1'b0;
        check("coll_stat_old", rd_data, 32'h0);
        check("coll_irq_kept", {31'd0, chg_irq}, 32'd1);
        do_read("coll_stat_new", STAT, 3'b000, 32'h2);

        // reset mid-debounce and mid-read
        in_port = 12'hC3F;
        tick(3);
        resetn = 1'b0;
        rd_en  = 1'b1;
        rd_sel = 3'd1;
        #1;
        check("arst_data", rd_data, 32'h0);
        check("arst_irq", {31'd0, chg_irq}, 32'd0);
        tick();
        rd_en   = 1'b0;
        in_port = 12'h000;
        check("arst_valid", {31'd0, rd_valid}, 32'd0);
        resetn = 1'b1;
        tick(8);
        check("post_rst_irq", {31'd0, chg_irq}, 32'd0);
        do_read("post_rst_stat", STAT, 3'b000, 32'h0);
        do_read("post_rst_ch1", 3'd1, 3'b000, 32'h0);

        // coherent sample: {3,7,9}, then ch0 -> 1
        in_port = 12'h973;
        tick(6);
        do_read("snap_stat", STAT, 3'b000, 32'h7);
        in_port = 12'h971;
        tick(6);
        check("snap_irq", {31'd0, chg_irq}, 32'd1);
`ifdef IO_SNAPSHOT_EN
        do_read("snap_ch0_old", 3'd0, 3'b000, 32'h3);
`else
        do_read("snap_ch0_live", 3'd0, 3'b000, 32'h1);
`endif
        do_read("snap_ch1", 3'd1, 3'b000, 32'h7);
        do_read("snap_stat2", STAT, 3'b000, 32'h1);
        do_read("snap_ch0_new", 3'd0, 3'b000, 32'h1);
        do_read("snap_ch2_sx", 3'd2, 3'b100, 32'hFFFFFFF9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
